// File: rtl/multi_chan_counter_pkg.sv
// Shared types and helpers for the multi-channel counter.
// Holds the channel mode enum and the prescaler width function.
package multi_chan_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_STOP = 1'b1
    } mode_e;

    // Prescaler register width; never below one bit.
    function automatic int presc_w(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multi_chan_counter_chan.sv
// One counter channel: count, hit and done registers.
// Ports: clk, reset_l, tick, en, clr, mode, limit -> count, hit, done, term.
module multi_chan_counter_chan
    import multi_chan_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             tick,
    input  logic             en,
    input  logic             clr,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             hit,
    output logic             done,
    output logic             term
);

    logic step;
    logic at_term;

    // A channel only evaluates on an enabled tick while not done.
    assign step    = tick & en & ~done;
    // Checking before incrementing means count can never overflow.
    assign at_term = (count >= limit);
    assign term    = step & at_term;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            count <= '0;
            hit   <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            hit   <= 1'b0;
            done  <= 1'b0;
        end else if (step) begin
            if (at_term) begin
                hit <= 1'b1;
                if (mode == MODE_STOP) begin
                    done <= 1'b1;
                end else begin
                    count <= '0;
                end
            end else begin
                count <= count + 1'b1;
                hit   <= 1'b0;
            end
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_chan_counter.sv
// CHANNELS independent up-counters on a shared prescaled tick.
// Ports: clk, reset_l, en, clr, mode, limit -> count, hit, done, all_done.
module multi_chan_counter
    import multi_chan_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS-1:0]       done,
    output logic                      all_done
);

    logic                tick;
    logic [CHANNELS-1:0] term;

    // Free-running prescaler, independent of en and clr.
    if (PRESCALE == 1) begin : g_nopresc
        assign tick = 1'b1;
    end else begin : g_presc
        localparam int PW = presc_w(PRESCALE);
        localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

        logic [PW-1:0] presc;

        always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                presc <= '0;
            end else if (presc == PLAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end

        assign tick = (presc == PLAST);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        multi_chan_counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset_l (reset_l),
            .tick    (tick),
            .en      (en[i]),
            .clr     (clr[i]),
            .mode    (mode_e'(mode[i])),
            .limit   (limit[i*WIDTH +: WIDTH]),
            .count   (count[i*WIDTH +: WIDTH]),
            .hit     (hit[i]),
            .done    (done[i]),
            .term    (term[i])
        );

        if (PRESCALE > 1) begin : g_hit_chk
            a_hit_single: assert property (
                @(posedge clk) disable iff (!reset_l)
                hit[i] |=> !hit[i]
            );
        end

        a_done_stop: assert property (
            @(posedge clk) disable iff (!reset_l)
            done[i] |-> (mode[i] == MODE_STOP || clr[i])
        );

        c_wrap_hit: cover property (
            @(posedge clk) disable iff (!reset_l)
            hit[i] && !done[i]
        );

        c_stop_done: cover property (
            @(posedge clk) disable iff (!reset_l)
            $rose(done[i])
        );

        c_clr_term: cover property (
            @(posedge clk) disable iff (!reset_l)
            clr[i] && term[i]
        );
    end

    // Any WRAP channel keeps this low.
    assign all_done = &done;

endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench for multi_chan_counter.
// Runs a PRESCALE=1 and a PRESCALE=4 instance side by side.
module tb_multi_chan_counter;

    logic        clk;
    logic        reset_l;

    logic [1:0]  en;
    logic [1:0]  clr;
    logic [1:0]  mode;
    logic [15:0] limit;
    logic [15:0] count;
    logic [1:0]  hit;
    logic [1:0]  done;
    logic        all_done;

    logic [1:0]  en4;
    logic [1:0]  clr4;
    logic [1:0]  mode4;
    logic [15:0] limit4;
    logic [15:0] count4;
    logic [1:0]  hit4;
    logic [1:0]  done4;
    logic        all_done4;

    int total;
    int bad;

    multi_chan_counter #(
        .WIDTH    (8),
        .CHANNELS (2),
        .PRESCALE (1)
    ) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .en       (en),
        .clr      (clr),
        .mode     (mode),
        .limit    (limit),
        .count    (count),
        .hit      (hit),
        .done     (done),
        .all_done (all_done)
    );

    multi_chan_counter #(
        .WIDTH    (8),
        .CHANNELS (2),
        .PRESCALE (4)
    ) dut4 (
        .clk      (clk),
        .reset_l  (reset_l),
        .en       (en4),
        .clr      (clr4),
        .mode     (mode4),
        .limit    (limit4),
        .count    (count4),
        .hit      (hit4),
        .done     (done4),
        .all_done (all_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int e0;
        int e1;
        int e4;
        total   = 0;
        bad     = 0;
        reset_l = 1'b0;
        en      = 2'b11;
        clr     = 2'b00;
        mode    = 2'b10;
        limit   = {8'd5, 8'd3};
        en4     = 2'b01;
        clr4    = 2'b00;
        mode4   = 2'b00;
        limit4  = {8'd0, 8'd2};

        #2;
        check("rst_count", 32'(count), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_done", 32'(done), 0);
        check("rst_alldone", 32'(all_done), 0);
        check("rst_count4", 32'(count4), 0);

        @(negedge clk);
        reset_l = 1'b1;

        // Free run: ch0 WRAP/3, ch1 STOP/5, dut4 ch0 WRAP/2.
        for (int k = 1; k <= 30; k++) begin
            en4[0] = !(k >= 17 && k <= 24);
            step();
            e0 = k % 4;
            e1 = (k < 5) ? k : 5;
            if (k <= 16)
                e4 = (k / 4) % 3;
            else if (k < 28)
                e4 = 1;
            else
                e4 = 2;
            check("wrap_count0", 32'(count[7:0]), e0);
            check("wrap_hit0", 32'(hit[0]), (e0 == 0) ? 1 : 0);
            check("wrap_done0", 32'(done[0]), 0);
            check("stop_count1", 32'(count[15:8]), e1);
            check("stop_hit1", 32'(hit[1]), (k == 6) ? 1 : 0);
            check("stop_done1", 32'(done[1]), (k >= 6) ? 1 : 0);
            check("p4_count0", 32'(count4[7:0]), e4);
            check("p4_hit0", 32'(hit4[0]), (k == 12) ? 1 : 0);
        end

        // Clear the stopped channel.
        clr = 2'b10;
        step();
        check("clr1_count1", 32'(count[15:8]), 0);
        check("clr1_done1", 32'(done[1]), 0);
        check("clr1_count0", 32'(count[7:0]), 3);

        // clr on ch0 coincides with a terminal tick.
        clr = 2'b01;
        step();
        check("clrterm_count0", 32'(count[7:0]), 0);
        check("clrterm_hit0", 32'(hit[0]), 0);
        check("clrterm_done0", 32'(done[0]), 0);
        check("clrterm_count1", 32'(count[15:8]), 1);

        // Lower the limit below the current count.
        clr = 2'b00;
        limit[7:0] = 8'd200;
        for (int k = 0; k < 50; k++) step();
        check("lim_count0_50", 32'(count[7:0]), 50);
        check("lim_hit0_pre", 32'(hit[0]), 0);
        limit[7:0] = 8'd10;
        step();
        check("lim_count0_wrap", 32'(count[7:0]), 0);
        check("lim_hit0", 32'(hit[0]), 1);

        // Both STOP, limits 2 and 7.
        mode  = 2'b11;
        limit = {8'd7, 8'd2};
        clr   = 2'b11;
        step();
        check("ad_clr_count", 32'(count), 0);
        check("ad_clr_done", 32'(done), 0);
        check("ad_clr_all", 32'(all_done), 0);
        clr = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("ad_count0", 32'(count[7:0]), (k < 2) ? k : 2);
            check("ad_done0", 32'(done[0]), (k >= 3) ? 1 : 0);
            check("ad_hit0", 32'(hit[0]), (k == 3) ? 1 : 0);
            check("ad_count1", 32'(count[15:8]), (k < 7) ? k : 7);
            check("ad_done1", 32'(done[1]), (k >= 8) ? 1 : 0);
            check("ad_all", 32'(all_done), (k >= 8) ? 1 : 0);
        end
        step();
        step();
        check("ad_frozen1", 32'(count[15:8]), 7);
        check("ad_nohit", 32'(hit), 0);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        reset_l = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_hit", 32'(hit), 0);
        check("arst_done", 32'(done), 0);
        check("arst_all", 32'(all_done), 0);
        check("arst_count4", 32'(count4), 0);
        @(negedge clk);
        reset_l = 1'b1;
        step();
        check("post_count0", 32'(count[7:0]), 1);
        check("post_count1", 32'(count[15:8]), 1);
        check("post_done", 32'(done), 0);
        check("post_count4", 32'(count4[7:0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
